// File: rtl/sipo_word_assembler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sipo_word_assembler_pkg
// Brief    : Shared constants for the serial-to-word assembler and its
//            output buffer. The default width matches the upstream
//            parallel-load shift register.
// Revision : 1.0 - initial release
// ============================================================================
package sipo_word_assembler_pkg;

  // Word width shared with the upstream shift register.
  localparam int C_DEFAULT_WIDTH = 4;

  // Number of completed words the output buffer can hold.
  localparam int C_BUF_DEPTH = 2;

endpackage : sipo_word_assembler_pkg
`default_nettype wire

// File: rtl/sipo_word_assembler_if.sv
`default_nettype none
// ============================================================================
// Module   : sipo_word_assembler_if
// Brief    : Bundles the serial input side and the word valid/ready side
//            of the assembler. The slave modport is the assembler's view;
//            master is the view of whatever drives and consumes it.
// Revision : 1.0 - initial release
// ============================================================================
interface sipo_word_assembler_if
  import sipo_word_assembler_pkg::*;
#(
  parameter int WIDTH = C_DEFAULT_WIDTH
);

  // Serial side
  logic                       bit_valid;
  logic                       bit_in;
  logic                       clr;

  // Word side
  logic [WIDTH-1:0]           word_out;
  logic                       word_valid;
  logic                       word_ready;

  // Status
  logic [$clog2(WIDTH)-1:0]   bit_count;
  logic                       overflow;

  modport slave (
    input  bit_valid,
    input  bit_in,
    input  clr,
    input  word_ready,
    output word_out,
    output word_valid,
    output bit_count,
    output overflow
  );

  modport master (
    output bit_valid,
    output bit_in,
    output clr,
    output word_ready,
    input  word_out,
    input  word_valid,
    input  bit_count,
    input  overflow
  );

endinterface : sipo_word_assembler_if
`default_nettype wire

// File: rtl/sipo_word_assembler_word_fifo2.sv
`default_nettype none
// ============================================================================
// Module   : word_fifo2
// Brief    : Two-entry synchronous FIFO. A push while full is accepted only
//            if a pop happens on the same edge; the head reads 0 when empty.
// Revision : 1.0 - initial release
// ============================================================================
module word_fifo2
  import sipo_word_assembler_pkg::*;
#(
  parameter int WIDTH = C_DEFAULT_WIDTH
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             push,
  input  wire logic [WIDTH-1:0] push_data,
  input  wire logic             pop,
  output logic      [WIDTH-1:0] head,
  output logic                  empty,
  output logic                  full
);

  logic [WIDTH-1:0] mem_q [C_BUF_DEPTH];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;

  logic             w_do_push;
  logic             w_do_pop;

  assign empty = (cnt_q == 2'd0);
  assign full  = (cnt_q == 2'(C_BUF_DEPTH));

  // When full, the write slot is the head slot; it is only overwritten
  // on the same edge that pops it.
  assign w_do_push = push && (!full || pop);
  assign w_do_pop  = pop && !empty;

  assign head = empty ? '0 : mem_q[rd_ptr_q];

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr_q ^ w_do_push;
    rd_ptr_d = rd_ptr_q ^ w_do_pop;
    cnt_d    = cnt_q;
    case ({w_do_push, w_do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer, occupancy and storage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      for (int i = 0; i < C_BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (w_do_push) begin
        mem_q[wr_ptr_q] <= push_data;
      end
    end
  end

endmodule : word_fifo2
`default_nettype wire

// File: rtl/sipo_word_assembler.sv
`default_nettype none
// ============================================================================
// Module   : sipo_word_assembler
// Brief    : Collects a serial bit stream MSB-first into WIDTH-bit words and
//            offers them through a two-entry buffer on a valid/ready port.
//            The serial side cannot stall, so a word completed while the
//            buffer is full and not draining is dropped and flagged.
// Revision : 1.0 - initial release
// ============================================================================
module sipo_word_assembler
  import sipo_word_assembler_pkg::*;
#(
  parameter int WIDTH = C_DEFAULT_WIDTH
) (
  input  wire logic             clk,
  input  wire logic             rst,
  sipo_word_assembler_if.slave  bus
);

  localparam int C_CNT_W = $clog2(WIDTH);

  // Only the low WIDTH-1 bits of the partial word are ever needed: the
  // completing bit is taken straight from the input.
  logic [WIDTH-2:0]   shreg_q, shreg_d;
  logic [C_CNT_W-1:0] cnt_q, cnt_d;
  logic               ovf_q, ovf_d;

  logic               w_last;
  logic               w_accept;
  logic               w_complete;
  logic [WIDTH-1:0]   w_word;
  logic               w_pop;
  logic               w_drop;
  logic [WIDTH-1:0]   w_head;
  logic               w_empty;
  logic               w_full;

  assign w_last     = (cnt_q == C_CNT_W'(WIDTH - 1));
  assign w_accept   = bus.bit_valid && !bus.clr;
  assign w_complete = w_accept && w_last;
  assign w_word     = {shreg_q, bus.bit_in};
  assign w_pop      = !w_empty && bus.word_ready;
  assign w_drop     = w_complete && w_full && !w_pop;

  // Shifter, bit counter and sticky overflow next-state.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q | w_drop;
    if (bus.clr) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (bus.bit_valid) begin
      shreg_d = (WIDTH - 1)'({shreg_q, bus.bit_in});
      cnt_d   = w_last ? '0 : cnt_q + 1'b1;
    end
  end

  // State registers; reset discards the partial word and the flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  word_fifo2 #(
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_complete),
    .push_data (w_word),
    .pop       (w_pop),
    .head      (w_head),
    .empty     (w_empty),
    .full      (w_full)
  );

  assign bus.word_out   = w_head;
  assign bus.word_valid = !w_empty;
  assign bus.bit_count  = cnt_q;
  assign bus.overflow   = ovf_q;

endmodule : sipo_word_assembler
`default_nettype wire

// File: tb/tb_sipo_word_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sipo_word_assembler
// Brief    : Directed self-checking bench for sipo_word_assembler (WIDTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sipo_word_assembler;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  sipo_word_assembler_if #(.WIDTH(4)) bus ();

  sipo_word_assembler #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
    tick();
  endtask

  task automatic send_bit(input logic b);
    bus.bit_valid = 1'b1;
    bus.bit_in    = b;
    tick();
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic chk_outs(input string tag, input logic [3:0] wo, input logic wv,
                          input logic [1:0] bc, input logic ov);
    chk({tag, ".word_out"},   32'(bus.word_out),   32'(wo));
    chk({tag, ".word_valid"}, 32'(bus.word_valid), 32'(wv));
    chk({tag, ".bit_count"},  32'(bus.bit_count),  32'(bc));
    chk({tag, ".overflow"},   32'(bus.overflow),   32'(ov));
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst           = 1'b1;
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
    bus.clr       = 1'b0;
    bus.word_ready = 1'b0;

    // Reset state
    tick();
    tick();
    chk_outs("reset", 4'h0, 1'b0, 2'd0, 1'b0);
    rst = 1'b0;

    // Back-to-back bits 1,0,1,0 with ready high
    bus.word_ready = 1'b1;
    send_bit(1'b1); chk("t1.cnt1", 32'(bus.bit_count), 32'd1);
    chk("t1.nv1", 32'(bus.word_valid), 32'd0);
    send_bit(1'b0); chk("t1.cnt2", 32'(bus.bit_count), 32'd2);
    send_bit(1'b1); chk("t1.cnt3", 32'(bus.bit_count), 32'd3);
    chk("t1.nv3", 32'(bus.word_valid), 32'd0);
    send_bit(1'b0); chk_outs("t1.word", 4'hA, 1'b1, 2'd0, 1'b0);
    idle();         chk_outs("t1.popped", 4'h0, 1'b0, 2'd0, 1'b0);

    // Gapped bits 1,1,0,1; count holds during gaps
    send_bit(1'b1); chk("t2.cnt1", 32'(bus.bit_count), 32'd1);
    idle();         chk("t2.gap1", 32'(bus.bit_count), 32'd1);
    send_bit(1'b1); chk("t2.cnt2", 32'(bus.bit_count), 32'd2);
    idle();         chk("t2.gap2", 32'(bus.bit_count), 32'd2);
    send_bit(1'b0); chk("t2.cnt3", 32'(bus.bit_count), 32'd3);
    idle();         chk("t2.gap3", 32'(bus.bit_count), 32'd3);
    chk("t2.nv", 32'(bus.word_valid), 32'd0);
    send_bit(1'b1); chk_outs("t2.word", 4'hD, 1'b1, 2'd0, 1'b0);
    idle();         chk("t2.popped", 32'(bus.word_valid), 32'd0);

    // Overflow: 3 and 5 buffered, 9 dropped
    bus.word_ready = 1'b0;
    send_word(4'h3); chk_outs("t3.w3", 4'h3, 1'b1, 2'd0, 1'b0);
    send_word(4'h5); chk_outs("t3.w5", 4'h3, 1'b1, 2'd0, 1'b0);
    send_word(4'h9); chk_outs("t3.w9drop", 4'h3, 1'b1, 2'd0, 1'b1);
    bus.word_ready = 1'b1;
    idle();          chk_outs("t3.pop3", 4'h5, 1'b1, 2'd0, 1'b1);
    idle();          chk_outs("t3.pop5", 4'h0, 1'b0, 2'd0, 1'b1);
    idle();          chk("t3.sticky", 32'(bus.overflow), 32'd1);

    // Reset clears overflow
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_outs("t4.rst", 4'h0, 1'b0, 2'd0, 1'b0);

    // Full buffer, completion coincides with pop
    bus.word_ready = 1'b0;
    send_word(4'h3);
    send_word(4'h5);
    chk_outs("t4.full", 4'h3, 1'b1, 2'd0, 1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    chk("t4.cnt3", 32'(bus.bit_count), 32'd3);
    bus.word_ready = 1'b1;
    send_bit(1'b1);  chk_outs("t4.pushpop", 4'h5, 1'b1, 2'd0, 1'b0);
    idle();          chk_outs("t4.head9", 4'h9, 1'b1, 2'd0, 1'b0);
    idle();          chk_outs("t4.empty", 4'h0, 1'b0, 2'd0, 1'b0);

    // clr together with bit_valid after 2 bits
    bus.word_ready = 1'b0;
    send_word(4'hF); chk_outs("t5.wF", 4'hF, 1'b1, 2'd0, 1'b0);
    send_bit(1'b1); send_bit(1'b0);
    chk("t5.cnt2", 32'(bus.bit_count), 32'd2);
    bus.clr = 1'b1;
    send_bit(1'b1);
    bus.clr = 1'b0;
    chk_outs("t5.clr", 4'hF, 1'b1, 2'd0, 1'b0);
    send_word(4'h6); chk_outs("t5.w6", 4'hF, 1'b1, 2'd0, 1'b0);
    bus.word_ready = 1'b1;
    idle();          chk_outs("t5.head6", 4'h6, 1'b1, 2'd0, 1'b0);
    idle();          chk_outs("t5.empty", 4'h0, 1'b0, 2'd0, 1'b0);

    // Reset mid-word with one buffered word
    bus.word_ready = 1'b0;
    send_word(4'hA); chk_outs("t6.wA", 4'hA, 1'b1, 2'd0, 1'b0);
    send_bit(1'b1); send_bit(1'b1);
    chk("t6.cnt2", 32'(bus.bit_count), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_outs("t6.rst", 4'h0, 1'b0, 2'd0, 1'b0);
    bus.word_ready = 1'b1;
    idle();          chk_outs("t6.lost", 4'h0, 1'b0, 2'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_sipo_word_assembler
`default_nettype wire
